nts_ip_tx_header: RTL
=====================

Name: nts_ip_tx_header

Overview:
- Builds the Ethernet II / IPv4 / UDP header for an outgoing NTS response packet and streams it as 64-bit big-endian words.
- It is the transmit-side counterpart of the receive-path IP/UDP parser and uses the same word layout.
- It sits ahead of the TX payload mux. The payload mux appends the NTP/NTS payload after the last header word.
- The IPv4 header checksum is computed sequentially. The block also keeps a per-packet IPv4 identification counter.

Parameters:
- TTL, 8'd64, IPv4 time-to-live inserted in every header.
- MAX_PAYLOAD, 16'd1472, largest UDP payload length in bytes that is accepted.

Ports:
- i_clk  in  1  clock.
- i_areset_n  in  1  asynchronous reset, active low.
- i_clear  in  1  synchronous abort; returns the block to IDLE.
- i_start  in  1  request to build a header; sampled only in IDLE.
- i_mac_dst  in  48  destination MAC.
- i_mac_src  in  48  source MAC.
- i_ip_src  in  32  IPv4 source address.
- i_ip_dst  in  32  IPv4 destination address.
- i_udp_src  in  16  UDP source port.
- i_udp_dst  in  16  UDP destination port.
- i_payload_len  in  16  UDP payload length in bytes.
- i_ready  in  1  downstream accepts the current word.
- o_valid  out  1  o_data holds a valid header word.
- o_data  out  64  header word; byte 0 is in [63:56].
- o_last  out  1  current word is the final header word.
- o_last_word_data_valid  out  8  byte-valid mask for the last word, MSB = byte 0; zero when o_last=0.
- o_busy  out  1  block is not in IDLE.
- o_error  out  1  one-cycle pulse when a request is rejected.

Behaviour:

Reset (i_areset_n=0, asynchronous):
- State goes to IDLE and the ident counter to 16'h0000.
- All outputs are 0.

States:
- IDLE → CSUM → FOLD → EMIT → IDLE.

IDLE:
- If i_start=1 and i_payload_len > MAX_PAYLOAD: pulse o_error for 1 cycle and stay in IDLE. Nothing is latched.
- Otherwise, if i_start=1: latch all inputs, compute total_len = payload+28 and udp_len = payload+8 (16-bit), clear the accumulator, and go to CSUM.

CSUM, 10 cycles:
- Each cycle, add one 16-bit IPv4 header word (checksum field taken as 0) into a 20-bit accumulator.
- Word order: 16'h4500, total_len, ident, 16'h4000, {TTL, 8'h11}, ip_src hi, ip_src lo, ip_dst hi, ip_dst lo, and the zero checksum word.

FOLD, 1 cycle:
- sum = acc[15:0] + acc[19:16]; add the carry again.
- checksum = ~sum[15:0].

EMIT:
- o_valid=1 from the first EMIT cycle. That is exactly 12 cycles after the cycle in which i_start was accepted.
- Word k advances only when o_valid && i_ready. While i_ready=0, o_data and o_last are held stable.
- Word layout:
  - w0 = {mac_dst, mac_src[47:32]}
  - w1 = {mac_src[31:0], 16'h0800, 16'h4500}
  - w2 = {total_len, ident, 16'h4000, TTL, 8'h11}
  - w3 = {checksum, ip_src, ip_dst[31:16]}
  - w4 = {ip_dst[15:0], udp_src, udp_dst, udp_len}
  - w5 = {16'h0000 (UDP checksum unused), 48'h0}, with o_last=1 and o_last_word_data_valid=8'hC0.
- When w5 is accepted: ident increments (wraps at 16'hFFFF→16'h0000), o_valid deasserts on the next cycle, and the state returns to IDLE.

Handshake and control:
- Back-to-back packets: a new i_start is accepted only in the cycle after the return to IDLE.
- i_start outside IDLE is ignored, with no o_error.
- i_clear in any state: next state is IDLE, and o_valid, o_last, o_busy and o_error go to 0. ident is unchanged because the packet was not sent. i_clear wins over a simultaneous i_start.
- Reset asserted mid-packet: immediate IDLE with all outputs 0.
- o_busy = (state != IDLE).
- i_payload_len = MAX_PAYLOAD is accepted; MAX_PAYLOAD+1 is rejected.

Test Plan:
1. Checksum vector.
   - Stimulus: after reset, ip_src=c0a80001, ip_dst=c0a800c7, payload_len=87, TTL=64, ready=1.
   - Expected: w2=0073_0000_4000_4011, w3[63:48]=16'hB861, o_valid first high 12 cycles after start, 6 consecutive words, o_last only on w5 with mask 8'hC0.
2. Field placement.
   - Stimulus: mac_dst=2c768aadf786, mac_src=902b34312734, udp_src=0x1234, udp_dst=0x007B (123), payload_len=48.
   - Expected: w0=2c768aadf786902b, w1=3431273408004500, w4[47:0]=1234_007B_0038, w2[63:48]=0x004C.
3. Backpressure.
   - Stimulus: hold i_ready=0 for 5 cycles on w3, then pulse i_ready every other cycle.
   - Expected: o_data stable while stalled, no word duplicated or skipped, ident=1 in the following packet.
4. Rejection and boundary.
   - Stimulus: payload_len=1473, then payload_len=1472.
   - Expected: the first gives a single o_error pulse with o_busy staying 0 and no o_valid; the second is accepted with total_len=0x05DC.
5. Abort.
   - Stimulus: i_clear asserted during CSUM, and separately after w2 is accepted.
   - Expected: o_valid=0 and o_busy=0 on the next cycle, ident not incremented; the next start re-emits from w0 with the same ident.
6. Ident wrap and reset.
   - Stimulus: force 65536 packets (or preload via a sequence of starts), then assert i_areset_n=0 mid-EMIT.
   - Expected: ident wraps FFFF→0000; on reset all outputs drop to 0 asynchronously and ident=0.

Source files
------------

// File: rtl/nts_ip_tx_header.sv
// Ethernet II / IPv4 / UDP header generator for outgoing NTS responses.
// Streams six 64-bit big-endian words; the IPv4 checksum is summed one word per cycle.
`timescale 1ns/1ps
module nts_ip_tx_header #(
  parameter logic [7:0]  TTL         = 8'd64,
  parameter logic [15:0] MAX_PAYLOAD = 16'd1472
) (
  input  logic        i_clk,
  input  logic        i_areset_n,
  input  logic        i_clear,
  input  logic        i_start,
  input  logic [47:0] i_mac_dst,
  input  logic [47:0] i_mac_src,
  input  logic [31:0] i_ip_src,
  input  logic [31:0] i_ip_dst,
  input  logic [15:0] i_udp_src,
  input  logic [15:0] i_udp_dst,
  input  logic [15:0] i_payload_len,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [63:0] o_data,
  output logic        o_last,
  output logic [7:0]  o_last_word_data_valid,
  output logic        o_busy,
  output logic        o_error,
  output logic [1:0]  o_dbg_state
);

  // Handshake: a word transfers on a cycle where o_valid && i_ready; while
  // i_ready is low o_data/o_last hold the same word.

  typedef enum logic [1:0] {S_IDLE, S_CSUM, S_FOLD, S_EMIT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [19:0] acc_q, acc_d;
  logic [15:0] csum_q, csum_d;
  logic [15:0] ident_q, ident_d;
  logic [47:0] mac_dst_q, mac_dst_d, mac_src_q, mac_src_d;
  logic [31:0] ip_src_q, ip_src_d, ip_dst_q, ip_dst_d;
  logic [15:0] udp_src_q, udp_src_d, udp_dst_q, udp_dst_d;
  logic [15:0] total_len_q, total_len_d, udp_len_q, udp_len_d;
  logic        error_q, error_d;

  logic [15:0] csum_word;
  logic [16:0] fold1;
  logic [15:0] fold2;
  logic [63:0] emit_word;

  // IPv4 header words in checksum order; the checksum field itself counts as zero.
  always_comb begin
    csum_word = 16'h0000;
    case (cnt_q)
      4'd0: csum_word = 16'h4500;
      4'd1: csum_word = total_len_q;
      4'd2: csum_word = ident_q;
      4'd3: csum_word = 16'h4000;
      4'd4: csum_word = {TTL, 8'h11};
      4'd5: csum_word = ip_src_q[31:16];
      4'd6: csum_word = ip_src_q[15:0];
      4'd7: csum_word = ip_dst_q[31:16];
      4'd8: csum_word = ip_dst_q[15:0];
      default: csum_word = 16'h0000;
    endcase
  end

  assign fold1 = {1'b0, acc_q[15:0]} + {13'd0, acc_q[19:16]};
  assign fold2 = fold1[15:0] + {15'd0, fold1[16]};

  always_comb begin
    emit_word = 64'd0;
    case (cnt_q)
      4'd0: emit_word = {mac_dst_q, mac_src_q[47:32]};
      4'd1: emit_word = {mac_src_q[31:0], 16'h0800, 16'h4500};
      4'd2: emit_word = {total_len_q, ident_q, 16'h4000, TTL, 8'h11};
      4'd3: emit_word = {csum_q, ip_src_q, ip_dst_q[31:16]};
      4'd4: emit_word = {ip_dst_q[15:0], udp_src_q, udp_dst_q, udp_len_q};
      default: emit_word = 64'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    csum_d      = csum_q;
    ident_d     = ident_q;
    mac_dst_d   = mac_dst_q;
    mac_src_d   = mac_src_q;
    ip_src_d    = ip_src_q;
    ip_dst_d    = ip_dst_q;
    udp_src_d   = udp_src_q;
    udp_dst_d   = udp_dst_q;
    total_len_d = total_len_q;
    udp_len_d   = udp_len_q;
    error_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (i_payload_len > MAX_PAYLOAD) begin
            error_d = 1'b1;
          end else begin
            mac_dst_d   = i_mac_dst;
            mac_src_d   = i_mac_src;
            ip_src_d    = i_ip_src;
            ip_dst_d    = i_ip_dst;
            udp_src_d   = i_udp_src;
            udp_dst_d   = i_udp_dst;
            total_len_d = i_payload_len + 16'd28;
            udp_len_d   = i_payload_len + 16'd8;
            acc_d       = 20'd0;
            cnt_d       = 4'd0;
            state_d     = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        acc_d = acc_q + {4'd0, csum_word};
        if (cnt_q == 4'd9) begin
          cnt_d   = 4'd0;
          state_d = S_FOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_FOLD: begin
        csum_d  = ~fold2;
        cnt_d   = 4'd0;
        state_d = S_EMIT;
      end
      S_EMIT: begin
        if (i_ready) begin
          if (cnt_q == 4'd5) begin
            ident_d = ident_q + 16'd1;
            cnt_d   = 4'd0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort: the packet never went out, so ident stays put.
    if (i_clear) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      error_d = 1'b0;
      ident_d = ident_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_areset_n) begin
    if (!i_areset_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      acc_q       <= 20'd0;
      csum_q      <= 16'd0;
      ident_q     <= 16'd0;
      mac_dst_q   <= 48'd0;
      mac_src_q   <= 48'd0;
      ip_src_q    <= 32'd0;
      ip_dst_q    <= 32'd0;
      udp_src_q   <= 16'd0;
      udp_dst_q   <= 16'd0;
      total_len_q <= 16'd0;
      udp_len_q   <= 16'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      csum_q      <= csum_d;
      ident_q     <= ident_d;
      mac_dst_q   <= mac_dst_d;
      mac_src_q   <= mac_src_d;
      ip_src_q    <= ip_src_d;
      ip_dst_q    <= ip_dst_d;
      udp_src_q   <= udp_src_d;
      udp_dst_q   <= udp_dst_d;
      total_len_q <= total_len_d;
      udp_len_q   <= udp_len_d;
      error_q     <= error_d;
    end
  end

  assign o_valid                = (state_q == S_EMIT);
  assign o_data                 = o_valid ? emit_word : 64'd0;
  assign o_last                 = o_valid && (cnt_q == 4'd5);
  assign o_last_word_data_valid = o_last ? 8'hC0 : 8'h00;
  assign o_busy                 = (state_q != S_IDLE);
  assign o_error                = error_q;
  assign o_dbg_state            = state_q;

endmodule
